// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the arbiter and the shared RAM.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_arbiter_if #(
    parameter int unsigned RAM_AW = 10
);
    // Fetch port
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    // Load/store port
    logic              d_req;
    logic [31:0]       d_addr;
    logic [3:0]        d_we;
    logic [31:0]       d_wdata;
    logic              d_lock;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    // RAM side
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_lock, ram_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_lock, ram_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, one access per cycle.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating contention; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int unsigned RAM_AW      = 10,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned MAX_WAIT    = 8
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    localparam logic [0:0] StArb  = 1'b0;
    localparam logic [0:0] StLock = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [WaitW-1:0]       fetch_wait_q, fetch_wait_d;
    logic [RAM_LATENCY-1:0] vld_q, vld_d;
    logic [RAM_LATENCY-1:0] own_q, own_d;
    logic [31:0]            i_rdata_q, i_rdata_d;
    logic [31:0]            d_rdata_q, d_rdata_d;

    logic locked;
    logic contested;
    logic force_fetch;
    logic gnt_i;
    logic gnt_d;
    logic rsp_i;
    logic rsp_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // High when the next contested cycle goes to the data port.
    logic rr_q, rr_d;
`endif

    logic unused_addr;
    assign unused_addr = ^{bus.i_addr[31:RAM_AW+2], bus.i_addr[1:0],
                           bus.d_addr[31:RAM_AW+2], bus.d_addr[1:0]};

    // Arbitration. Grants are gated by rst_n so nothing is accepted while in reset.
    always_comb begin
        gnt_i       = 1'b0;
        gnt_d       = 1'b0;
        locked      = (state_q == StLock) && bus.d_lock;
        contested   = bus.i_req && bus.d_req;
        force_fetch = (fetch_wait_q == WaitW'(MAX_WAIT));
        if (!rst_n) begin
            gnt_i = 1'b0;
            gnt_d = 1'b0;
        end else if (locked) begin
            gnt_d = bus.d_req;
        end else if (contested) begin
            if (force_fetch) begin
                gnt_i = 1'b1;
            end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                gnt_d = rr_q;
                gnt_i = ~rr_q;
`else
                gnt_d = 1'b1;
`endif
            end
        end else begin
            gnt_i = bus.i_req;
            gnt_d = bus.d_req;
        end
    end

    // Lock persists while d_lock stays high once a locked data grant was taken.
    always_comb begin
        state_d = StArb;
        if (bus.d_lock && (gnt_d || (state_q == StLock))) begin
            state_d = StLock;
        end
    end

    always_comb begin
        fetch_wait_d = '0;
        if (bus.i_req && !gnt_i) begin
            fetch_wait_d = force_fetch ? fetch_wait_q : fetch_wait_q + WaitW'(1);
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_d = rr_q;
        if (contested && !locked && rst_n) begin
            rr_d = gnt_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // RAM drive for the granted requester, same cycle as the grant.
    assign bus.i_gnt     = gnt_i;
    assign bus.d_gnt     = gnt_d;
    assign bus.ram_en    = gnt_i | gnt_d;
    assign bus.ram_we    = gnt_d ? bus.d_we : 4'b0000;
    assign bus.ram_addr  = gnt_d ? bus.d_addr[RAM_AW+1:2] : bus.i_addr[RAM_AW+1:2];
    assign bus.ram_wdata = gnt_d ? bus.d_wdata : 32'h0;

    // Owner tag pipeline matching the RAM read latency; own = 1 marks the data port.
    always_comb begin
        vld_d    = vld_q;
        own_d    = own_q;
        vld_d[0] = gnt_i | gnt_d;
        own_d[0] = gnt_d;
        for (int k = 1; k < int'(RAM_LATENCY); k++) begin
            vld_d[k] = vld_q[k-1];
            own_d[k] = own_q[k-1];
        end
    end

    assign rsp_i = vld_q[RAM_LATENCY-1] & ~own_q[RAM_LATENCY-1];
    assign rsp_d = vld_q[RAM_LATENCY-1] &  own_q[RAM_LATENCY-1];

    always_comb begin
        i_rdata_d = rsp_i ? bus.ram_rdata : i_rdata_q;
        d_rdata_d = rsp_d ? bus.ram_rdata : d_rdata_q;
    end

    assign bus.i_rvalid = rsp_i;
    assign bus.d_rvalid = rsp_d;
    assign bus.i_rdata  = i_rdata_d;
    assign bus.d_rdata  = d_rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StArb;
            fetch_wait_q <= '0;
            vld_q        <= '0;
            own_q        <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_wait_q <= fetch_wait_d;
            vld_q        <= vld_d;
            own_q        <= own_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: two DUTs (RAM latency 1 and 2) share stimulus
// and are checked against a transaction-level model of grants and RAM contents.
module tb_mem_arbiter;
    localparam int unsigned RAM_AW   = 10;
    localparam int unsigned MAX_WAIT = 8;
    localparam int unsigned DEPTH    = 1 << RAM_AW;
    localparam byte CD = 8'h44;
    localparam byte CI = 8'h49;

    typedef struct {
        logic        is_d;
        logic        is_wr;
        logic [31:0] data;
        int          due;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        bit          lock;
    } dreq_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        i_req = 1'b0, d_req = 1'b0, d_lock = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_we = '0;

    mem_arbiter_if #(.RAM_AW(RAM_AW)) bus1 ();
    mem_arbiter_if #(.RAM_AW(RAM_AW)) bus2 ();

    assign bus1.i_req = i_req;   assign bus2.i_req = i_req;
    assign bus1.i_addr = i_addr; assign bus2.i_addr = i_addr;
    assign bus1.d_req = d_req;   assign bus2.d_req = d_req;
    assign bus1.d_addr = d_addr; assign bus2.d_addr = d_addr;
    assign bus1.d_we = d_we;     assign bus2.d_we = d_we;
    assign bus1.d_wdata = d_wdata; assign bus2.d_wdata = d_wdata;
    assign bus1.d_lock = d_lock; assign bus2.d_lock = d_lock;

    mem_arbiter #(.RAM_AW(RAM_AW), .RAM_LATENCY(1), .MAX_WAIT(MAX_WAIT)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    mem_arbiter #(.RAM_AW(RAM_AW), .RAM_LATENCY(2), .MAX_WAIT(MAX_WAIT)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    // Environment RAMs, one per latency
    logic [31:0] mem1 [DEPTH];
    logic [31:0] mem2 [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] rd1_q, rd2a_q, rd2b_q;

    always @(posedge clk) begin
        if (bus1.ram_en) begin
            rd1_q <= mem1[bus1.ram_addr];
            for (int b = 0; b < 4; b++)
                if (bus1.ram_we[b]) mem1[bus1.ram_addr][8*b +: 8] <= bus1.ram_wdata[8*b +: 8];
        end
        if (bus2.ram_en) begin
            rd2a_q <= mem2[bus2.ram_addr];
            for (int b = 0; b < 4; b++)
                if (bus2.ram_we[b]) mem2[bus2.ram_addr][8*b +: 8] <= bus2.ram_wdata[8*b +: 8];
        end
        rd2b_q <= rd2a_q;
    end
    assign bus1.ram_rdata = rd1_q;
    assign bus2.ram_rdata = rd2b_q;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int w, input logic [31:0] act,
                            input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d) at cycle %0d: actual 0x%08h required 0x%08h",
                     name, w + 1, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference model state
    resp_t q1[$], q2[$];
    int    m_wait;
    bit    m_lock, m_fav_d;
    bit    exp_igr = 1'b0, exp_dgr = 1'b0;
    bit    log_en = 1'b0;
    byte   glog[$];

    logic             e_ig, e_dg, e_en;
    logic [3:0]       e_we;
    logic [RAM_AW-1:0] e_addr;

    task automatic chk_grant(input int w, input logic ig, input logic dg, input logic en,
                             input logic [3:0] we, input logic [RAM_AW-1:0] addr,
                             input logic [31:0] wd);
        check_eq("i_gnt", w, 32'(ig), 32'(e_ig));
        check_eq("d_gnt", w, 32'(dg), 32'(e_dg));
        check_eq("ram_en", w, 32'(en), 32'(e_en));
        check_eq("ram_we", w, 32'(we), 32'(e_we));
        if (e_en) check_eq("ram_addr", w, 32'(addr), 32'(e_addr));
        if (e_dg && d_we != 4'b0) check_eq("ram_wdata", w, wd, d_wdata);
    endtask

    always @(negedge clk) begin
        resp_t r;
        bit locked;
        e_ig = 1'b0;
        e_dg = 1'b0;
        if (rst_n) begin
            locked = m_lock && d_lock;
            if (locked) e_dg = d_req;
            else if (i_req && d_req) begin
                if (m_wait >= int'(MAX_WAIT)) e_ig = 1'b1;
                else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    e_dg = m_fav_d;
                    e_ig = !m_fav_d;
`else
                    e_dg = 1'b1;
`endif
                end
            end else begin
                e_ig = i_req;
                e_dg = d_req;
            end
        end
        e_en   = e_ig | e_dg;
        e_we   = e_dg ? d_we : 4'b0;
        e_addr = e_dg ? d_addr[RAM_AW+1:2] : i_addr[RAM_AW+1:2];
        chk_grant(0, bus1.i_gnt, bus1.d_gnt, bus1.ram_en, bus1.ram_we, bus1.ram_addr,
                  bus1.ram_wdata);
        chk_grant(1, bus2.i_gnt, bus2.d_gnt, bus2.ram_en, bus2.ram_we, bus2.ram_addr,
                  bus2.ram_wdata);
        if (log_en && (bus1.i_gnt || bus1.d_gnt)) glog.push_back(bus1.d_gnt ? CD : CI);
        if (e_en) begin
            r.is_d  = e_dg;
            r.is_wr = e_dg && (d_we != 4'b0);
            r.data  = ref_mem[e_addr];
            r.due   = cyc + 1;
            q1.push_back(r);
            r.due   = cyc + 2;
            q2.push_back(r);
            if (r.is_wr)
                for (int b = 0; b < 4; b++)
                    if (d_we[b]) ref_mem[e_addr][8*b +: 8] = d_wdata[8*b +: 8];
        end
        if (!rst_n) begin
            m_wait = 0; m_lock = 1'b0; m_fav_d = 1'b1;
        end else begin
            if (i_req && d_req && !(m_lock && d_lock)) m_fav_d = e_ig;
            m_lock = d_lock && (e_dg || m_lock);
            if (i_req && !e_ig) m_wait = (m_wait < int'(MAX_WAIT)) ? m_wait + 1 : m_wait;
            else m_wait = 0;
        end
        exp_igr = e_ig;
        exp_dgr = e_dg;
    end

    // Response monitor
    logic [31:0] last_i[2], last_d[2];
    bit          ld_ok[2];

    function automatic int qsize(input int w);
        return (w == 0) ? q1.size() : q2.size();
    endfunction
    function automatic resp_t qfront(input int w);
        return (w == 0) ? q1[0] : q2[0];
    endfunction
    function automatic void qpop(input int w);
        if (w == 0) void'(q1.pop_front()); else void'(q2.pop_front());
    endfunction

    task automatic mon(input int w, input logic iv, input logic [31:0] id, input logic dv,
                       input logic [31:0] dd);
        resp_t f;
        bit has;
        if (!rst_n) begin
            if (w == 0) q1.delete(); else q2.delete();
            check_eq("rvalid_in_reset", w, {30'b0, iv, dv}, 32'h0);
            check_eq("rdata_in_reset", w, id | dd, 32'h0);
            last_i[w] = '0; last_d[w] = '0; ld_ok[w] = 1'b1;
            return;
        end
        while (qsize(w) > 0 && qfront(w).due < cyc) begin
            fail_now($sformatf("response_missing dut%0d", w + 1));
            qpop(w);
        end
        has = (qsize(w) > 0) && (qfront(w).due == cyc);
        if (has) f = qfront(w);
        check_eq("i_rvalid", w, 32'(iv), 32'(has && !f.is_d));
        check_eq("d_rvalid", w, 32'(dv), 32'(has && f.is_d));
        if (has) begin
            qpop(w);
            if (!f.is_d) begin
                check_eq("i_rdata", w, id, f.data);
                last_i[w] = f.data;
            end else if (!f.is_wr) begin
                check_eq("d_rdata", w, dd, f.data);
                last_d[w] = f.data;
                ld_ok[w]  = 1'b1;
            end else begin
                ld_ok[w] = 1'b0;
            end
        end
        if (!iv && !(has && !f.is_d)) check_eq("i_rdata_hold", w, id, last_i[w]);
        if (!dv && !(has && f.is_d) && ld_ok[w]) check_eq("d_rdata_hold", w, dd, last_d[w]);
    endtask

    always @(negedge clk) begin
        mon(0, bus1.i_rvalid, bus1.i_rdata, bus1.d_rvalid, bus1.d_rdata);
        mon(1, bus2.i_rvalid, bus2.i_rdata, bus2.d_rvalid, bus2.d_rdata);
    end

    // Requesters: hold each request until the model says it was granted
    logic [31:0] ipend[$];
    dreq_t       dpend[$];
    bit          i_busy = 1'b0, d_busy = 1'b0, d_cur_lock = 1'b0, idle_lock = 1'b0;

    task automatic step();
        dreq_t r;
        if (i_busy && exp_igr) i_busy = 1'b0;
        if (d_busy && exp_dgr) d_busy = 1'b0;
        if (!i_busy && ipend.size() > 0) begin
            i_addr = ipend.pop_front();
            i_busy = 1'b1;
        end
        if (!d_busy && dpend.size() > 0) begin
            r = dpend.pop_front();
            d_addr = r.addr; d_we = r.we; d_wdata = r.wdata; d_cur_lock = r.lock;
            d_busy = 1'b1;
        end
        i_req  = i_busy;
        d_req  = d_busy;
        d_lock = d_busy ? d_cur_lock : idle_lock;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        step();
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((ipend.size() > 0 || dpend.size() > 0 || i_busy || d_busy) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) fail_now("request_timeout");
        repeat (4) cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[RAM_AW+1:2] = RAM_AW'($urandom_range(0, 31));
        return a;
    endfunction

    function automatic dreq_t mk_d(input logic [31:0] a, input logic [3:0] we,
                                   input logic [31:0] wd, input bit lk);
        dreq_t r;
        r.addr = a; r.we = we; r.wdata = wd; r.lock = lk;
        return r;
    endfunction

    task automatic check_log(input byte pat[$]);
        for (int k = 0; k < pat.size(); k++)
            check_eq($sformatf("grant_order[%0d]", k), 0,
                     (k < glog.size()) ? 32'(glog[k]) : 32'h0, 32'(pat[k]));
        glog.delete();
        log_en = 1'b0;
    endtask

    initial begin
        byte pat[$];
        dreq_t r;
        for (int k = 0; k < int'(DEPTH); k++) begin
            mem1[k] = '0; mem2[k] = '0; ref_mem[k] = '0;
        end
        mem1[4] = 32'hDEADBEEF; mem2[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single fetch of word 4
        ipend.push_back(32'h10);
        run(20);

        // Partial store then load of 0x20
        dpend.push_back(mk_d(32'h20, 4'b0011, 32'h12345678, 1'b0));
        dpend.push_back(mk_d(32'h20, 4'b0000, 32'h0, 1'b0));
        run(20);

        // Both ports continuously requesting
        for (int k = 0; k < 12; k++) begin
            ipend.push_back(32'(k * 4));
            dpend.push_back(mk_d(32'(k * 4 + 64), 4'b0, 32'h0, 1'b0));
        end
        log_en = 1'b1;
        run(60);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pat = '{CD, CI, CD, CI};
`else
        pat = '{CD, CD, CD, CD, CD, CD, CD, CD, CI};
`endif
        check_log(pat);

        // Locked sequence of three data accesses with fetch pending
        for (int k = 0; k < 3; k++) dpend.push_back(mk_d(32'(k * 4 + 128), 4'b0, 32'h0, 1'b1));
        log_en = 1'b1;
        cycle();
        ipend.push_back(32'h40);
        run(40);
        pat = '{CD, CD, CD, CI};
        check_log(pat);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if (ipend.size() < 2 && $urandom_range(0, 2) == 0) ipend.push_back(rand_addr());
            if (dpend.size() < 2 && $urandom_range(0, 2) == 0) begin
                r = mk_d(rand_addr(), ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15))
                         : 4'b0, $urandom, ($urandom_range(0, 3) == 0));
                dpend.push_back(r);
            end
            idle_lock = ($urandom_range(0, 7) == 0);
            cycle();
        end
        idle_lock = 1'b0;
        run(300);

        // Reset one cycle after a grant, with a data request held through reset
        ipend.push_back(32'h10);
        cycle();
        dpend.push_back(mk_d(32'h24, 4'b0, 32'h0, 1'b0));
        cycle();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(20);

        // More random traffic after reset
        for (int n = 0; n < 800; n++) begin
            if (ipend.size() < 2 && $urandom_range(0, 1) == 0) ipend.push_back(rand_addr());
            if (dpend.size() < 2 && $urandom_range(0, 1) == 0) begin
                r = mk_d(rand_addr(), ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15))
                         : 4'b0, $urandom, ($urandom_range(0, 5) == 0));
                dpend.push_back(r);
            end
            cycle();
        end
        run(300);

        check_eq("resp_queue_empty", 0, 32'(q1.size()), 32'h0);
        check_eq("resp_queue_empty", 1, 32'(q2.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
